fdc_disk_sequencer: RTL and testbench
=====================================

# fdc_disk_sequencer

Sequences the FDC's disk-side command word (`disk_sr`) into single transactions on the sector-storage backend (SD/image loader) and builds the FDC's completion word (`disk_cr`). It sits between the `nec765` instance and the backend. Read, write and read-ID requests are forwarded one at a time. Seeks are executed locally with a per-step delay and a per-drive track register.

## Interface
- `STEP_CYCLES`, default 32000: clock cycles per track step during a seek. Must be ≥1.
- `MAX_TRACK`, default 83: highest legal track. A seek target above this fails.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `disk_sr` in 32: FDC request word.
  - [7:0] sector
  - [14:8] track
  - [15] head
  - [16] FDC ack-of-done
  - [18:17] read sector, drive 1/0
  - [21:20] write sector, drive 1/0
  - [23:22] read ID, drive 1/0
  - [25:24] seek, drive 1/0
- `disk_cr` out 32: completion word to FDC.
  - [31:24] sector ID from read-ID
  - [6:5] inserted, drive 1/0
  - [4] done
  - [3] error
  - [1:0] seek done, drive 1/0
  - All other bits 0.
- `disk_inserted` in 2: image mounted, per drive.
- `cmd_valid` out 1 / `cmd_ready` in 1: backend command handshake.
- `cmd_op` out 2: 0 read, 1 write, 2 read-ID.
- `cmd_drive` out 1, `cmd_track` out 7, `cmd_head` out 1, `cmd_sector` out 8: fields latched from `disk_sr`.
- `rsp_valid` in 1: one-cycle backend completion pulse.
- `rsp_error` in 1: error flag, qualified by `rsp_valid`.
- `rsp_id` in 8: sector ID, qualified by `rsp_valid`.
- `busy` out 1: high in any state except IDLE.

## Operation
- Reset values:
  - `disk_cr` = 0 except [6:5] = `disk_inserted` on the next cycle.
  - `cmd_valid` = 0.
  - `busy` = 0.
  - Both track registers = 0.
  - State = IDLE.
- `disk_cr[6:5]` is `disk_inserted` registered every cycle, independent of state.
- In IDLE, requests are sampled every cycle. If several request bits are set, the fixed priority is read > write > read-ID > seek, and drive 0 beats drive 1. The selected op, drive, track, head and sector are latched.
- States:
  - **IDLE**
    - A read, write or read-ID request on a drive with `disk_inserted` set → ISSUE.
    - The same request on a non-inserted drive → DONE with error = 1.
    - A seek request → SEEK.
  - **ISSUE**: `cmd_valid` = 1 with stable fields until `cmd_valid && cmd_ready`, then → WAIT_RSP.
  - **WAIT_RSP**: on `rsp_valid`, capture `rsp_error` into the error flag and `rsp_id` into `disk_cr[31:24]` (read-ID only), then → DONE.
  - **SEEK**
    - If the target is > `MAX_TRACK` or the drive is not inserted: error = 1, no steps.
    - Otherwise step the drive's track register by ±1 every `STEP_CYCLES` cycles until it equals the target. A target equal to the current track takes zero steps.
    - Then → DONE.
  - **DONE**
    - Non-seek ops: drive `disk_cr[4]` = 1 and `disk_cr[3]` = error.
    - Seek: drive `disk_cr[1]` or `disk_cr[0]` (by drive) = 1 and `disk_cr[3]` = error.
    - → WAIT_CLR.
  - **WAIT_CLR**: hold the done/error bits until the latched op's request bit pair in `disk_sr` reads 00. Then clear [4], [3] and [1:0] and → IDLE. `disk_cr[31:24]` keeps its value until the next read-ID.
- A request bit that drops while in ISSUE or WAIT_RSP does not abort the transaction. The transaction completes and WAIT_CLR then exits immediately.
- Track arithmetic is 7-bit unsigned; the direction comes from a magnitude compare. Read, write and read-ID do not alter the track registers.

## Timing
- Request to `cmd_valid`: 2 cycles (IDLE latch, then ISSUE).
- `rsp_valid` to `disk_cr[4]`: 2 cycles (capture, then DONE register).
- Seek of N steps: N·`STEP_CYCLES` + 3 cycles from request to `disk_cr[1:0]`.
- A `rsp_valid` outside WAIT_RSP is ignored.
- `rst` mid-operation:
  - Immediate return to IDLE.
  - `cmd_valid` drops the next cycle.
  - Track registers cleared.
  - An outstanding backend response is later ignored.

## Structure
- Shared package `fdc_pkg`:
  - `disk_sr`/`disk_cr` bit-position constants.
  - `cmd_op` encodings.
  - State enum.
- One sub-module, `fdc_step_timer`:
  - Down-counter loaded with `STEP_CYCLES-1`.
  - Emits a one-cycle `step` pulse and reloads.
  - Enabled only in SEEK.

## Test plan
- Read, drive 0, track 5, sector 0xC3, `cmd_ready` tied high → `cmd_op`=0, `cmd_track`=5, `cmd_sector`=0xC3. Backend `rsp_valid` with `rsp_error`=0 → `disk_cr[4]`=1, [3]=0. Clearing sr[18:17] → [4]=0 one cycle later.
- Read-ID, drive 1, `rsp_id`=0x41 → `disk_cr[31:24]`=0x41, [4]=1. The value persists after sr[23:22] clears.
- Seek drive 0 from 0 to 3 with `STEP_CYCLES`=4 → `disk_cr[0]` rises at cycle 15. A following seek to 3 takes zero steps.
- Seek to track 90, and separately a read on a drive with `disk_inserted`=0 → error bit set, no `cmd_valid` ever asserted.
- Read and seek requested together → the read is served first, the seek after WAIT_CLR. `cmd_ready` held low 10 cycles → `cmd_valid` and all fields stable throughout.
- `rst` asserted in WAIT_RSP, then a late `rsp_valid` → `disk_cr[4]` stays 0, `busy`=0, track registers = 0.

Source files
------------

// File: rtl/fdc_pkg.sv
// Shared definitions for the FDC disk-side sequencer: word layouts, op codes, states.
package fdc_pkg;

  localparam int unsigned SR_W          = 32;
  localparam int unsigned CR_W          = 32;
  localparam int unsigned TRACK_W       = 7;
  localparam int unsigned SECTOR_W      = 8;

  // disk_sr field positions
  localparam int unsigned SR_SECTOR_LSB = 0;
  localparam int unsigned SR_TRACK_LSB  = 8;
  localparam int unsigned SR_HEAD       = 15;
  localparam int unsigned SR_ACK        = 16;
  localparam int unsigned SR_RD_LSB     = 17;
  localparam int unsigned SR_WR_LSB     = 20;
  localparam int unsigned SR_ID_LSB     = 22;
  localparam int unsigned SR_SK_LSB     = 24;

  // disk_cr field positions
  localparam int unsigned CR_ID_LSB     = 24;
  localparam int unsigned CR_INS_LSB    = 5;
  localparam int unsigned CR_DONE       = 4;
  localparam int unsigned CR_ERR        = 3;
  localparam int unsigned CR_SEEK_LSB   = 0;

  // Backend op encoding; OP_SEEK never reaches the backend.
  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_RDID  = 2'd2,
    OP_SEEK  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_SEEK     = 3'd3,
    ST_DONE     = 3'd4,
    ST_WAIT_CLR = 3'd5
  } state_e;

  // Latched request as seen by the backend.
  typedef struct packed {
    op_e                 op;
    logic                drive;
    logic [TRACK_W-1:0]  track;
    logic                head;
    logic [SECTOR_W-1:0] sector;
  } req_t;

  // Request bit pair {drive1, drive0} belonging to an op.
  function automatic logic [1:0] req_pair(input logic [SR_W-1:0] sr, input op_e op);
    logic [1:0] pair;
    case (op)
      OP_READ:  pair = sr[SR_RD_LSB +: 2];
      OP_WRITE: pair = sr[SR_WR_LSB +: 2];
      OP_RDID:  pair = sr[SR_ID_LSB +: 2];
      default:  pair = sr[SR_SK_LSB +: 2];
    endcase
    return pair;
  endfunction

endpackage

// File: rtl/fdc_step_timer.sv
// Per-step delay for seeks: one-cycle step pulse every STEP_CYCLES enabled cycles.
module fdc_step_timer
  import fdc_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 32000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic step_c
);

  localparam int unsigned    CNT_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Down-counter: held at reload while disabled, reloads after each step.
  always_ff @(posedge clk) begin
    if (rst || !en || (cnt_q == '0)) cnt_q <= RELOAD;
    else                              cnt_q <= cnt_q - CNT_W'(1);
  end

  assign step_c = en && (cnt_q == '0);

endmodule

// File: rtl/fdc_disk_sequencer.sv
// Turns the FDC disk_sr request word into single backend transactions or local
// seeks, and builds the disk_cr completion word.
module fdc_disk_sequencer
  import fdc_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 32000,
  parameter int unsigned MAX_TRACK   = 83
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disk_sr,
  output logic [31:0] disk_cr,
  input  logic [1:0]  disk_inserted,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_op,
  output logic        cmd_drive,
  output logic [6:0]  cmd_track,
  output logic        cmd_head,
  output logic [7:0]  cmd_sector,
  input  logic        rsp_valid,
  input  logic        rsp_error,
  input  logic [7:0]  rsp_id,
  output logic        busy
);

  state_e state_q, state_d;
  req_t   req_q, req_d;
  logic   err_lat_q, err_lat_d;
  logic [7:0] id_q, id_d;
  logic   done_q, done_d;
  logic   err_q, err_d;
  logic [1:0] seek_done_q, seek_done_d;
  logic   cmd_valid_q, cmd_valid_d;
  logic   busy_q;
  logic [1:0][TRACK_W-1:0] trk_q, trk_d;
  logic [1:0] ins_q;

  logic [1:0] rd_pair, wr_pair, id_pair, sk_pair;
  logic       req_any;
  op_e        pick_op;
  logic       pick_drv;
  logic [TRACK_W-1:0] cur_trk;
  logic       step_c;
  logic [CR_W-1:0] cr_w;
  logic       unused_sr;

  assign rd_pair = disk_sr[SR_RD_LSB +: 2];
  assign wr_pair = disk_sr[SR_WR_LSB +: 2];
  assign id_pair = disk_sr[SR_ID_LSB +: 2];
  assign sk_pair = disk_sr[SR_SK_LSB +: 2];
  assign cur_trk = trk_q[req_q.drive];

  // FDC ack and spare bits carry no meaning for the sequencer.
  assign unused_sr = ^{disk_sr[31:26], disk_sr[19], disk_sr[SR_ACK]};

  fdc_step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == ST_SEEK),
    .step_c (step_c)
  );

  // Fixed-priority request pick: read > write > read-ID > seek, drive 0 first.
  always_comb begin
    req_any  = 1'b1;
    pick_op  = OP_READ;
    pick_drv = 1'b0;
    if (|rd_pair) begin
      pick_op  = OP_READ;
      pick_drv = ~rd_pair[0];
    end else if (|wr_pair) begin
      pick_op  = OP_WRITE;
      pick_drv = ~wr_pair[0];
    end else if (|id_pair) begin
      pick_op  = OP_RDID;
      pick_drv = ~id_pair[0];
    end else if (|sk_pair) begin
      pick_op  = OP_SEEK;
      pick_drv = ~sk_pair[0];
    end else begin
      req_any  = 1'b0;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    err_lat_d   = err_lat_q;
    id_d        = id_q;
    done_d      = done_q;
    err_d       = err_q;
    seek_done_d = seek_done_q;
    cmd_valid_d = cmd_valid_q;
    trk_d       = trk_q;

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          req_d.op     = pick_op;
          req_d.drive  = pick_drv;
          req_d.track  = disk_sr[SR_TRACK_LSB +: TRACK_W];
          req_d.head   = disk_sr[SR_HEAD];
          req_d.sector = disk_sr[SR_SECTOR_LSB +: SECTOR_W];
          err_lat_d    = 1'b0;
          if (pick_op == OP_SEEK) begin
            state_d = ST_SEEK;
          end else if (disk_inserted[pick_drv]) begin
            state_d = ST_ISSUE;
          end else begin
            err_lat_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end

      ST_ISSUE: begin
        if (!cmd_valid_q) begin
          cmd_valid_d = 1'b1;
        end else if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_WAIT_RSP;
        end
      end

      ST_WAIT_RSP: begin
        if (rsp_valid) begin
          err_lat_d = rsp_error;
          if (req_q.op == OP_RDID) id_d = rsp_id;
          state_d = ST_DONE;
        end
      end

      ST_SEEK: begin
        if ((32'(req_q.track) > MAX_TRACK) || !disk_inserted[req_q.drive]) begin
          err_lat_d = 1'b1;
          state_d   = ST_DONE;
        end else if (cur_trk == req_q.track) begin
          state_d = ST_DONE;
        end else if (step_c) begin
          trk_d[req_q.drive] = (req_q.track > cur_trk) ? cur_trk + 7'd1 : cur_trk - 7'd1;
        end
      end

      ST_DONE: begin
        err_d = err_lat_q;
        if (req_q.op == OP_SEEK) seek_done_d[req_q.drive] = 1'b1;
        else                     done_d = 1'b1;
        state_d = ST_WAIT_CLR;
      end

      ST_WAIT_CLR: begin
        if (req_pair(disk_sr, req_q.op) == 2'b00) begin
          done_d      = 1'b0;
          err_d       = 1'b0;
          seek_done_d = 2'b00;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q       <= '0;
      err_lat_q   <= 1'b0;
      id_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      seek_done_q <= 2'b00;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      trk_q       <= '0;
    end else begin
      req_q       <= req_d;
      err_lat_q   <= err_lat_d;
      id_q        <= id_d;
      done_q      <= done_d;
      err_q       <= err_d;
      seek_done_q <= seek_done_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= (state_d != ST_IDLE);
      trk_q       <= trk_d;
    end
  end

  // Media-present bits follow disk_inserted every cycle, reset or not.
  always_ff @(posedge clk) begin
    ins_q <= disk_inserted;
  end

  // Completion word assembly from registered fields.
  always_comb begin
    cr_w                     = '0;
    cr_w[CR_ID_LSB +: 8]     = id_q;
    cr_w[CR_INS_LSB +: 2]    = ins_q;
    cr_w[CR_DONE]            = done_q;
    cr_w[CR_ERR]             = err_q;
    cr_w[CR_SEEK_LSB +: 2]   = seek_done_q;
  end

  assign disk_cr    = cr_w;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_op     = req_q.op;
  assign cmd_drive  = req_q.drive;
  assign cmd_track  = req_q.track;
  assign cmd_head   = req_q.head;
  assign cmd_sector = req_q.sector;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fdc_disk_sequencer.sv
// Directed self-checking bench for fdc_disk_sequencer with STEP_CYCLES = 4.
module tb_fdc_disk_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] disk_sr;
  logic [31:0] disk_cr;
  logic [1:0]  disk_inserted;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_drive;
  logic [6:0]  cmd_track;
  logic        cmd_head;
  logic [7:0]  cmd_sector;
  logic        rsp_valid;
  logic        rsp_error;
  logic [7:0]  rsp_id;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cv_cnt   = 0;

  fdc_disk_sequencer #(
    .STEP_CYCLES(4),
    .MAX_TRACK  (83)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .disk_sr       (disk_sr),
    .disk_cr       (disk_cr),
    .disk_inserted (disk_inserted),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_drive     (cmd_drive),
    .cmd_track     (cmd_track),
    .cmd_head      (cmd_head),
    .cmd_sector    (cmd_sector),
    .rsp_valid     (rsp_valid),
    .rsp_error     (rsp_error),
    .rsp_id        (rsp_id),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle the backend command is offered.
  always @(posedge clk) if (cmd_valid === 1'b1) cv_cnt <= cv_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cmd_vec();
    return {12'd0, cmd_valid, cmd_op, cmd_drive, cmd_track, cmd_head, cmd_sector};
  endfunction

  function automatic logic [31:0] exp_vec(input logic [1:0] op, input logic drv,
                                          input logic [6:0] trk, input logic hd,
                                          input logic [7:0] sec);
    return {12'd0, 1'b1, op, drv, trk, hd, sec};
  endfunction

  // Issue a seek and return edges until the drive's seek-done bit rises (0 on timeout).
  task automatic run_seek(input logic drv, input logic [6:0] tgt, output int cyc);
    disk_sr = 32'd0;
    disk_sr[24 + int'(drv)] = 1'b1;
    disk_sr[14:8] = tgt;
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (disk_cr[drv] === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic clear_sr();
    disk_sr = 32'd0;
    tick();
  endtask

  initial begin
    int c;
    int cv0;

    rst = 1'b1; disk_sr = '0; disk_inserted = 2'b11; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_error = 1'b0; rsp_id = 8'h00;

    // Reset state
    repeat (3) tick();
    chk("rst_cr",   disk_cr,   32'h0000_0060);
    chk("rst_cv",   cmd_valid, 32'd0);
    chk("rst_busy", busy,      32'd0);
    rst = 1'b0;
    tick();
    chk("idle_cr", disk_cr, 32'h0000_0060);

    // Read, drive 0, track 5, sector C3
    cmd_ready = 1'b1;
    disk_sr = 32'h0002_05C3;
    tick();
    chk("rd_busy", busy, 32'd1);
    chk("rd_cv_lat", cmd_valid, 32'd0);
    tick();
    chk("rd_cmd", cmd_vec(), exp_vec(2'd0, 1'b0, 7'd5, 1'b0, 8'hC3));
    tick();
    chk("rd_hs", cmd_valid, 32'd0);
    rsp_valid = 1'b1; rsp_error = 1'b0; rsp_id = 8'h99;
    tick();
    rsp_valid = 1'b0;
    chk("rd_cap", disk_cr, 32'h0000_0060);
    tick();
    chk("rd_done", disk_cr, 32'h0000_0070);
    tick();
    chk("rd_hold", disk_cr, 32'h0000_0070);
    clear_sr();
    chk("rd_clr", disk_cr, 32'h0000_0060);
    chk("rd_idle", busy, 32'd0);

    // Read-ID, drive 1
    disk_sr = 32'h0080_0200;
    tick(); tick();
    chk("id_cmd", cmd_vec(), exp_vec(2'd2, 1'b1, 7'd2, 1'b0, 8'h00));
    tick();
    rsp_valid = 1'b1; rsp_id = 8'h41;
    tick();
    rsp_valid = 1'b0;
    tick();
    chk("id_done", disk_cr, 32'h4100_0070);
    clear_sr();
    chk("id_keep", disk_cr, 32'h4100_0060);

    // Write on both drives (drive 0 wins), backend error
    disk_sr = 32'h0030_8705;
    tick(); tick();
    chk("wr_cmd", cmd_vec(), exp_vec(2'd1, 1'b0, 7'd7, 1'b1, 8'h05));
    tick();
    rsp_valid = 1'b1; rsp_error = 1'b1; rsp_id = 8'h77;
    tick();
    rsp_valid = 1'b0; rsp_error = 1'b0;
    tick();
    chk("wr_err", disk_cr, 32'h4100_0078);
    disk_sr = 32'h0020_8705;
    tick();
    chk("wr_half", disk_cr, 32'h4100_0078);
    clear_sr();
    chk("wr_clr", disk_cr, 32'h4100_0060);

    // Seeks on drive 0: 0->3, 3->3, 3->1
    run_seek(1'b0, 7'd3, c);
    chk("sk03_cyc", c, 32'd15);
    chk("sk03_cr", disk_cr, 32'h4100_0061);
    clear_sr();
    chk("sk03_clr", disk_cr, 32'h4100_0060);
    run_seek(1'b0, 7'd3, c);
    chk("sk33_cyc", c, 32'd3);
    clear_sr();
    run_seek(1'b0, 7'd1, c);
    chk("sk31_cyc", c, 32'd11);
    clear_sr();

    // Error paths: out-of-range seek and read on empty drive
    cv0 = cv_cnt;
    run_seek(1'b0, 7'd90, c);
    chk("sk90_cyc", c, 32'd3);
    chk("sk90_cr", disk_cr, 32'h4100_0069);
    clear_sr();
    disk_inserted = 2'b01;
    tick();
    disk_sr = 32'h0004_0000;
    tick(); tick();
    chk("noins_cr", disk_cr, 32'h4100_0038);
    clear_sr();
    chk("noins_clr", disk_cr, 32'h4100_0020);
    disk_inserted = 2'b11;
    tick();
    chk("err_no_cv", cv_cnt, cv0);

    // Read and seek together, backend stalls 10 cycles
    cmd_ready = 1'b0;
    disk_sr = 32'h0102_0412;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      chk("stall_cmd", cmd_vec(), exp_vec(2'd0, 1'b0, 7'd4, 1'b0, 8'h12));
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    chk("stall_hs", cmd_valid, 32'd0);
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    tick();
    chk("both_rd", disk_cr, 32'h4100_0070);
    disk_sr = 32'h0100_0412;
    c = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (disk_cr[0] === 1'b1) begin
        c = i;
        break;
      end
    end
    chk("both_sk_cyc", c, 32'd16);
    chk("both_sk_cr", disk_cr, 32'h4100_0061);
    clear_sr();

    // Reset during WAIT_RSP, then a late response
    run_seek(1'b1, 7'd2, c);
    chk("sk1_cyc", c, 32'd11);
    chk("sk1_cr", disk_cr, 32'h4100_0062);
    clear_sr();
    disk_sr = 32'h0002_0000;
    tick(); tick(); tick();
    cmd_ready = 1'b0;
    disk_sr = 32'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_busy", busy, 32'd0);
    chk("rstw_cr", disk_cr, 32'h0000_0060);
    rsp_valid = 1'b1; rsp_id = 8'h55;
    tick();
    rsp_valid = 1'b0;
    tick(); tick();
    chk("late_cr", disk_cr, 32'h0000_0060);
    chk("late_busy", busy, 32'd0);
    run_seek(1'b1, 7'd0, c);
    chk("trk1_zero", c, 32'd3);
    clear_sr();
    run_seek(1'b0, 7'd0, c);
    chk("trk0_zero", c, 32'd3);
    clear_sr();

    // Reset while cmd_valid is offered
    disk_sr = 32'h0002_0000;
    tick(); tick();
    chk("rsti_cv", cmd_valid, 32'd1);
    rst = 1'b1;
    tick();
    chk("rsti_drop", cmd_valid, 32'd0);
    chk("rsti_busy", busy, 32'd0);
    rst = 1'b0;
    disk_sr = 32'd0;
    tick();
    chk("rsti_idle", cmd_valid, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
